// File: rtl/stopwatch_lap_timer.sv
// M:SS.d BCD stopwatch with start/stop, lap freeze, up/down count, preset load and tick prescaler.
// Optional leading-zero blanking of the minutes and seconds-tens digits: STOPWATCH_LEAD_ZERO_BLANK_EN.
module stopwatch_lap_timer #(
  parameter int CLK_DIV        = 10,
  parameter int MAX_MIN        = 9,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       mode,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [2:0] load_sec_t,
  input  logic [3:0] load_sec_u,
  input  logic [3:0] load_ds,
  output logic       running,
  output logic       done,
  output logic [6:0] Minutes_7_Seg,
  output logic [6:0] Second_L_7_Seg,
  output logic [6:0] Second_R_7_Seg,
  output logic [6:0] Decisecond_7_Seg
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]    MIN_LAST   = 4'(MAX_MIN);
  localparam logic [6:0]    SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [PW-1:0] presc, presc_next;
  logic [3:0]    cnt_min, cnt_su, cnt_ds;
  logic [2:0]    cnt_st;
  logic [3:0]    nxt_min, nxt_su, nxt_ds;
  logic [2:0]    nxt_st;
  logic [3:0]    disp_min, disp_su, disp_ds;
  logic [2:0]    disp_st;
  logic          frozen;
  logic          run_next, done_next;
  logic          tick, zero_now, zero_next;

  function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [2:0] sat_tens(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign tick     = running && (presc == PRESC_LAST);
  assign zero_now = (cnt_min == 4'd0) && (cnt_st == 3'd0) && (cnt_su == 4'd0) && (cnt_ds == 4'd0);

  always_comb begin
    nxt_min = cnt_min;
    nxt_st  = cnt_st;
    nxt_su  = cnt_su;
    nxt_ds  = cnt_ds;
    if (load) begin
      nxt_min = sat_digit(sat_digit(load_min, 4'd9), MIN_LAST);
      nxt_st  = sat_tens(load_sec_t);
      nxt_su  = sat_digit(load_sec_u, 4'd9);
      nxt_ds  = sat_digit(load_ds, 4'd9);
    end else if (tick && !mode) begin
      if (cnt_ds >= 4'd9) begin
        nxt_ds = 4'd0;
        if (cnt_su >= 4'd9) begin
          nxt_su = 4'd0;
          if (cnt_st >= 3'd5) begin
            nxt_st  = 3'd0;
            nxt_min = (cnt_min >= MIN_LAST) ? 4'd0 : cnt_min + 4'd1;
          end else begin
            nxt_st = cnt_st + 3'd1;
          end
        end else begin
          nxt_su = cnt_su + 4'd1;
        end
      end else begin
        nxt_ds = cnt_ds + 4'd1;
      end
    end else if (tick && mode) begin
      if (cnt_ds == 4'd0) begin
        nxt_ds = 4'd9;
        if (cnt_su == 4'd0) begin
          nxt_su = 4'd9;
          if (cnt_st == 3'd0) begin
            nxt_st  = 3'd5;
            nxt_min = (cnt_min == 4'd0) ? MIN_LAST : cnt_min - 4'd1;
          end else begin
            nxt_st = cnt_st - 3'd1;
          end
        end else begin
          nxt_su = cnt_su - 4'd1;
        end
      end else begin
        nxt_ds = cnt_ds - 4'd1;
      end
    end
  end

  assign zero_next = (nxt_min == 4'd0) && (nxt_st == 3'd0) && (nxt_su == 4'd0) && (nxt_ds == 4'd0);

  // Run/done control: load wins and swallows a coincident start_stop; a countdown
  // tick landing on zero forces a stop regardless of any stop pulse on the same edge.
  always_comb begin
    run_next   = running;
    done_next  = done;
    presc_next = presc;
    if (load) begin
      done_next  = 1'b0;
      presc_next = '0;
    end else begin
      if (running) presc_next = tick ? '0 : presc + 1'b1;
      if (start_stop && !(mode && zero_now)) begin
        run_next = !running;
        if (!running) done_next = 1'b0;
      end
      if (tick && mode && zero_next) begin
        run_next  = 1'b0;
        done_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      frozen   <= 1'b0;
      cnt_min  <= 4'd0;
      cnt_st   <= 3'd0;
      cnt_su   <= 4'd0;
      cnt_ds   <= 4'd0;
      disp_min <= 4'd0;
      disp_st  <= 3'd0;
      disp_su  <= 4'd0;
      disp_ds  <= 4'd0;
    end else begin
      presc   <= presc_next;
      running <= run_next;
      done    <= done_next;
      frozen  <= frozen ^ lap;
      cnt_min <= nxt_min;
      cnt_st  <= nxt_st;
      cnt_su  <= nxt_su;
      cnt_ds  <= nxt_ds;
      if (!frozen) begin
        disp_min <= nxt_min;
        disp_st  <= nxt_st;
        disp_su  <= nxt_su;
        disp_ds  <= nxt_ds;
      end
    end
  end

  // Segment decode straight off the display latch; blank is applied before polarity.
  always_comb begin
    Minutes_7_Seg    = seg7(disp_min);
    Second_L_7_Seg   = seg7({1'b0, disp_st});
    Second_R_7_Seg   = seg7(disp_su);
    Decisecond_7_Seg = seg7(disp_ds);
`ifdef STOPWATCH_LEAD_ZERO_BLANK_EN
    if (disp_min == 4'd0) begin
      Minutes_7_Seg = 7'b0000000;
      if (disp_st == 3'd0) Second_L_7_Seg = 7'b0000000;
    end
`endif
    Minutes_7_Seg    = Minutes_7_Seg ^ SEG_POL;
    Second_L_7_Seg   = Second_L_7_Seg ^ SEG_POL;
    Second_R_7_Seg   = Second_R_7_Seg ^ SEG_POL;
    Decisecond_7_Seg = Decisecond_7_Seg ^ SEG_POL;
  end

endmodule
